// File: rtl/latency_pkg.sv
// Shared types and defaults for the latency measurement-window controller.
package latency_pkg;
   localparam int W_DEF     = 32;
   localparam int WIN_W_DEF = 16;

   typedef logic [W_DEF-1:0]     w_t;
   typedef logic [WIN_W_DEF-1:0] win_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_DRAIN,
      S_DIV,
      S_DONE
   } lwc_state_t;

   // States in which the counter holds live window data.
   function automatic logic is_active(lwc_state_t s);
      return (s == S_CLEAR) || (s == S_RUN) || (s == S_DRAIN);
   endfunction
endpackage

// File: rtl/latency_window_ctrl_if.sv
// Control, event and result handshake bundle of the measurement-window controller.
interface latency_window_ctrl_if #(
   parameter int W     = latency_pkg::W_DEF,
   parameter int WIN_W = latency_pkg::WIN_W_DEF
);
   logic             start;
   logic             stop;
   logic [WIN_W-1:0] cfg_window;
   logic             ev_issue;
   logic             ev_retire;
   logic             busy;
   logic             result_vld;
   logic             result_rdy;
   logic [W-1:0]     result_issue;
   logic [W-1:0]     result_agg;
   logic [W-1:0]     result_avg;
   logic             underflow_err;

   modport master (
      output start, stop, cfg_window, ev_issue, ev_retire, result_rdy,
      input  busy, result_vld, result_issue, result_agg, result_avg, underflow_err
   );

   modport slave (
      input  start, stop, cfg_window, ev_issue, ev_retire, result_rdy,
      output busy, result_vld, result_issue, result_agg, result_avg, underflow_err
   );
endinterface

// File: rtl/latency.sv
// Issue / aggregate-latency counter: each in-flight transaction adds one per cycle.
module latency
   import latency_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         issue,
   input  logic         retire,
   output logic [W-1:0] issue_cnt_r,
   output logic [W-1:0] aggregate_cnt_r
);
   logic [W-1:0] outst_r;

   // Summing the outstanding count every cycle makes an issue at a and retire at b add b-a.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_cnt_r     <= '0;
         aggregate_cnt_r <= '0;
         outst_r         <= '0;
      end else if (clear) begin
         issue_cnt_r     <= '0;
         aggregate_cnt_r <= '0;
         outst_r         <= '0;
      end else begin
         if (issue) issue_cnt_r <= issue_cnt_r + W'(1);
         aggregate_cnt_r <= aggregate_cnt_r + outst_r;
         outst_r         <= outst_r + W'(issue) - W'(retire);
      end
   end
endmodule

// File: rtl/latency_div.sv
// Restoring radix-2 divider: W cycles per quotient, one cycle for a zero divisor.
module latency_div
   import latency_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         done,
   output logic [W-1:0] quotient
);
   localparam int CW = $clog2(W + 1);

   logic [W-1:0]  rem;
   logic [W-1:0]  quo;
   logic [W-1:0]  dvs;
   logic [CW-1:0] cnt;
   logic          run;
   logic          zero;
   logic [W:0]    rem_sh;
   logic          bit_q;
   logic [W-1:0]  rem_nxt;
   logic [W-1:0]  quo_nxt;

   always_comb begin
      rem_sh  = {rem, quo[W-1]};
      bit_q   = (rem_sh >= {1'b0, dvs});
      rem_nxt = bit_q ? W'(rem_sh - {1'b0, dvs}) : rem_sh[W-1:0];
      quo_nxt = zero ? '0 : {quo[W-2:0], bit_q};
   end

   // quotient is the value the final step produces, valid while done is high.
   assign done     = run && (cnt == CW'(1));
   assign quotient = quo_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem  <= '0;
         quo  <= '0;
         dvs  <= '0;
         cnt  <= '0;
         run  <= 1'b0;
         zero <= 1'b0;
      end else if (abort) begin
         run <= 1'b0;
      end else if (start) begin
         rem  <= '0;
         quo  <= dividend;
         dvs  <= divisor;
         zero <= (divisor == '0);
         cnt  <= (divisor == '0) ? CW'(1) : CW'(W);
         run  <= 1'b1;
      end else if (run) begin
         rem <= rem_nxt;
         quo <= quo_nxt;
         cnt <= cnt - CW'(1);
         if (cnt == CW'(1)) run <= 1'b0;
      end
   end
endmodule

// File: rtl/latency_window_ctrl.sv
// Measurement-window controller: clears and gates the latency counter, drains,
// then divides aggregate by issue count and hands the result out on valid/ready.
//
// state   | meaning
// IDLE    | waiting for start, last result held
// CLEAR   | one-cycle counter clear
// RUN     | window open, issue and retire forwarded
// DRAIN   | issues blocked, retires forwarded until nothing outstanding
// DIV     | mean latency being computed
// DONE    | result_vld high, waiting for result_rdy
module latency_window_ctrl
   import latency_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int WIN_W = WIN_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   latency_window_ctrl_if.slave  bus
);
   lwc_state_t       state;
   logic [WIN_W-1:0] win_cnt;
   logic [W-1:0]     outstanding;
   logic [W-1:0]     issue_cnt_r;
   logic [W-1:0]     aggregate_cnt_r;
   logic [W-1:0]     div_q;
   logic             div_done;

   logic             busy_r;
   logic             vld_r;
   logic             uf_r;
   logic [W-1:0]     res_issue_r;
   logic [W-1:0]     res_agg_r;
   logic [W-1:0]     res_avg_r;

   logic             abort;
   logic             fwd_issue;
   logic             fwd_retire;
   logic             uf_set;
   logic             cnt_clear;
   logic             div_start;
   logic             ev_open;

   always_comb begin
      ev_open    = (state == S_RUN) || (state == S_DRAIN);
      abort      = bus.stop && (state != S_IDLE);
      fwd_issue  = (state == S_RUN) && bus.ev_issue;
      // A retire is only real if something is in flight or issues in the same cycle.
      fwd_retire = ev_open && bus.ev_retire && ((outstanding != '0) || fwd_issue);
      uf_set     = ev_open && bus.ev_retire && !fwd_retire;
      cnt_clear  = (state == S_CLEAR) || (abort && is_active(state));
      div_start  = (state == S_DRAIN) && (outstanding == '0) && !bus.stop;
   end

   latency #(.W(W)) u_cnt (
      .clk             (clk),
      .rst             (rst),
      .clear           (cnt_clear),
      .issue           (fwd_issue),
      .retire          (fwd_retire),
      .issue_cnt_r     (issue_cnt_r),
      .aggregate_cnt_r (aggregate_cnt_r)
   );

   latency_div #(.W(W)) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .abort    (abort),
      .dividend (aggregate_cnt_r),
      .divisor  (issue_cnt_r),
      .done     (div_done),
      .quotient (div_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outstanding <= '0;
      end else if (cnt_clear) begin
         outstanding <= '0;
      end else begin
         outstanding <= outstanding + W'(fwd_issue) - W'(fwd_retire);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         win_cnt     <= '0;
         busy_r      <= 1'b0;
         vld_r       <= 1'b0;
         uf_r        <= 1'b0;
         res_issue_r <= '0;
         res_agg_r   <= '0;
         res_avg_r   <= '0;
      end else begin
         if (uf_set) uf_r <= 1'b1;
         if (abort) begin
            state  <= S_IDLE;
            busy_r <= 1'b0;
            vld_r  <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (bus.start) begin
                     state   <= S_CLEAR;
                     busy_r  <= 1'b1;
                     win_cnt <= bus.cfg_window;
                     uf_r    <= 1'b0;
                  end
               end
               S_CLEAR: begin
                  state <= (win_cnt != '0) ? S_RUN : S_DRAIN;
               end
               S_RUN: begin
                  win_cnt <= win_cnt - WIN_W'(1);
                  if (win_cnt == WIN_W'(1)) state <= S_DRAIN;
               end
               S_DRAIN: begin
                  if (outstanding == '0) begin
                     state       <= S_DIV;
                     res_issue_r <= issue_cnt_r;
                     res_agg_r   <= aggregate_cnt_r;
                  end
               end
               S_DIV: begin
                  if (div_done) begin
                     state     <= S_DONE;
                     vld_r     <= 1'b1;
                     res_avg_r <= div_q;
                  end
               end
               S_DONE: begin
                  if (bus.result_rdy) begin
                     state  <= S_IDLE;
                     vld_r  <= 1'b0;
                     busy_r <= 1'b0;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.busy          = busy_r;
   assign bus.result_vld    = vld_r;
   assign bus.underflow_err = uf_r;
   assign bus.result_issue  = res_issue_r;
   assign bus.result_agg    = res_agg_r;
   assign bus.result_avg    = res_avg_r;
endmodule

// File: doc/latency_window_ctrl.md
# latency_window_ctrl

Measurement-window controller for the `latency` counter block. It clears the counter, gates the monitored interface's issue and retire events into it for a programmable window, and drains transactions still in flight. It then snapshots the issue and aggregate counts, computes the mean latency with an iterative divider, and returns the result over a valid/ready handshake. It sits between the monitored request/response interface and the performance-readout logic.

## Interface
- `W`, default 32: counter and result width.
- `WIN_W`, default 16: window-length width.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: begin a measurement. Honoured only in IDLE.
- `stop`  in  1: abort the measurement. Returns to IDLE from any state except IDLE; no result is produced.
- `cfg_window`  in  `WIN_W`: window length in cycles, sampled on an accepted `start`.
- `ev_issue`  in  1: monitored transaction issued this cycle.
- `ev_retire`  in  1: monitored transaction retired this cycle.
- `busy`  out  1: state is not IDLE.
- `result_vld`  out  1: result available.
- `result_rdy`  in  1: result consumed when `result_vld & result_rdy`.
- `result_issue`  out  `W`: transactions counted in the window.
- `result_agg`  out  `W`: summed latency, in cycles.
- `result_avg`  out  `W`: `floor(result_agg / result_issue)`; 0 when `result_issue` is 0.
- `underflow_err`  out  1: sticky; set by a retire seen with zero outstanding; cleared on an accepted `start`.

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, DIV, DONE.
- IDLE:
  - `start` → CLEAR.
  - Latch `cfg_window` into `win_cnt`.
  - Clear `underflow_err`.
- CLEAR:
  - Drive counter `clear` for exactly one cycle.
  - → RUN if `win_cnt != 0`, else → DRAIN.
- RUN:
  - Forward `ev_issue` and `ev_retire` to the counter.
  - Decrement `win_cnt`; when it is 1 → DRAIN. RUN therefore lasts exactly `cfg_window` cycles.
- DRAIN:
  - `ev_issue` is blocked (not forwarded, not counted); `ev_retire` is forwarded.
  - → DIV when registered `outstanding == 0`.
- Outstanding count:
  - The controller keeps its own `W`-bit `outstanding` counter.
  - +1 on a forwarded issue, −1 on a forwarded retire; a simultaneous issue and retire leaves it unchanged.
- Retire with `outstanding == 0` (and no forwarded issue that cycle):
  - Not forwarded.
  - Sets `underflow_err`.
- Snapshot:
  - Taken on the DRAIN→DIV edge.
  - Registers `issue_cnt_r` → `result_issue` and `aggregate_cnt_r` → `result_agg`.
- DIV:
  - Restoring radix-2 division, one quotient bit per cycle, exactly `W` cycles.
  - Divisor 0: skip to DONE after 1 cycle with `result_avg = 0`.
- DONE:
  - `result_vld = 1`; result fields held stable.
  - On `result_rdy` → IDLE. A `start` in the same cycle is ignored.
- `stop`:
  - Has priority over every other transition.
  - In CLEAR/RUN/DRAIN it also clears `outstanding` and asserts counter `clear` for one cycle.
- Arithmetic is modulo 2^`W`; counter overflow is not detected.

## Timing
- Reset values:
  - State IDLE.
  - `busy`, `result_vld`, `underflow_err` are 0.
  - `result_issue`, `result_agg`, `result_avg`, `outstanding`, `win_cnt` are 0.
- `start` at cycle t:
  - CLEAR at t+1.
  - RUN over t+2 … t+1+`cfg_window`.
- An event forwarded in cycle c is visible in the counter registers at c+1.
- Latency accounting: an issue at cycle a with its retire at cycle b contributes b−a to the aggregate.
- DRAIN exit to `result_vld`:
  - `W`+1 cycles when `issue != 0`.
  - 2 cycles when `issue == 0`.
- `busy` asserts the cycle after an accepted `start` and deasserts the cycle after the handshake or `stop`.
- Mid-operation `rst` resets all state and results asynchronously.

## Structure
- Package `latency_pkg`:
  - State enum `lwc_state_t`.
  - `w_t` / `win_t` typedefs.
  - Default `W`/`WIN_W` constants.
- Sub-module `latency_div`: start/done restoring divider; its cycle count is fixed by `W`.
- The controller instantiates the existing `latency` counter, driving its `clear`, `issue` and `retire` and reading `issue_cnt_r` and `aggregate_cnt_r`.
- Target size: roughly 250 lines of RTL total.

## Test plan
- **Two transactions:** `cfg_window`=10; issue at RUN cycles 0 and 2, retires 3 and 5 cycles later → `result_issue`=2, `result_agg`=8, `result_avg`=4, `underflow_err`=0.
- **Drain past window end:** `cfg_window`=4; issue at RUN cycle 3, retire 20 cycles later → DRAIN holds for the retire; `result_agg`=20, `result_avg`=20. An issue during DRAIN is not counted.
- **Empty window:** `cfg_window`=0 → CLEAR→DRAIN→DIV→DONE with all results 0 and `result_vld` within 4 cycles of `start`.
- **Simultaneous events and underflow:** same-cycle issue+retire with `outstanding`=1 → `outstanding` stays 1. A retire with `outstanding`=0 → not forwarded, `underflow_err`=1 until the next `start`.
- **Abort and reset:** `stop` mid-RUN → IDLE next cycle, no `result_vld`, counter cleared. `rst` during DIV → all outputs 0 immediately.
- **Handshake backpressure:** hold `result_rdy`=0 for 5 cycles → results stable and `start` ignored. `result_rdy`=1 → IDLE, and a new `start` is accepted the following cycle.
